wl_sfifo: RTL and testbench

WL_SFIFO -- requirements
Module: wl_sfifo

---
 rtl/wl_fifo_pkg.sv | 26 ++
 rtl/wl_sdpram.sv | 33 +++
 rtl/wl_sfifo.sv | 122 ++++++++++++
 tb/tb_wl_sfifo.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/wl_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wl_fifo_pkg
// Brief   : Shared width helper and read-mode constants for the wl FIFO family.
// Revision: 1.0
// ============================================================================
package wl_fifo_pkg;

    localparam int FWFT_REG  = 0;
    localparam int FWFT_FALL = 1;

    // Ceiling of log2(n); returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int v;
        int r;
        v = n - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wl_sdpram.sv
`default_nettype none
// ============================================================================
// Module  : wl_sdpram
// Brief   : Simple dual-port RAM, W x H, one clock, asynchronous read port.
// Revision: 1.0
// ============================================================================
module wl_sdpram
    import wl_fifo_pkg::*;
#(
    parameter int W = 32,
    parameter int H = 100
) (
    input  logic                                     clk,
    input  logic                                     we,
    input  logic [((clog2(H) < 1) ? 1 : clog2(H))-1:0] waddr,
    input  logic [W-1:0]                             wdata,
    input  logic [((clog2(H) < 1) ? 1 : clog2(H))-1:0] raddr,
    output logic [W-1:0]                             rdata
);

    logic [W-1:0] r_mem [0:H-1];

    // Contents are intentionally left untouched by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/wl_sfifo.sv
`default_nettype none
// ============================================================================
// Module  : wl_sfifo
// Brief   : Synchronous FIFO with any depth, threshold flags, FWFT option.
// Revision: 1.0
// ============================================================================
module wl_sfifo
    import wl_fifo_pkg::*;
#(
    parameter int W    = 32,
    parameter int H    = 100,
    parameter int TA   = 8,
    parameter int TB   = 2,
    parameter int FWFT = FWFT_REG
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   clr,
    input  logic [W-1:0]           din,
    input  logic                   we,
    input  logic                   re,
    output logic [W-1:0]           dout,
    output logic                   wfull,
    output logic                   rempty,
    output logic                   awfull,
    output logic                   arempty,
    output logic                   overflow,
    output logic                   underflow,
    output logic [clog2(H+1)-1:0]  count
);

    localparam int L  = (clog2(H) < 1) ? 1 : clog2(H);
    localparam int CW = clog2(H + 1);

    localparam logic [L-1:0]  c_last = L'(H - 1);
    localparam logic [CW-1:0] c_full = CW'(H);
    localparam logic [CW-1:0] c_af   = CW'(H - TA);
    localparam logic [CW-1:0] c_ae   = CW'(TB);

    logic [L-1:0]  r_wptr;
    logic [L-1:0]  r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_underflow;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic [W-1:0]  w_rdata;

    // Flags decode only the registered count, so they lag an operation by one edge.
    assign wfull     = (r_count == c_full);
    assign rempty    = (r_count == '0);
    assign awfull    = (r_count >= c_af);
    assign arempty   = (r_count <= c_ae);
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    assign w_wr_ok = we && !wfull  && !clr;
    assign w_rd_ok = re && !rempty && !clr;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= (r_wptr == c_last) ? '0 : r_wptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + 1'b1;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow  <= we && wfull;
            r_underflow <= re && rempty;
        end
    end

    wl_sdpram #(
        .W (W),
        .H (H)
    ) u_ram (
        .clk   (clk),
        .we    (w_wr_ok),
        .waddr (r_wptr),
        .wdata (din),
        .raddr (r_rptr),
        .rdata (w_rdata)
    );

    generate
        if (FWFT == FWFT_FALL) begin : g_fwft
            assign dout = w_rdata;
        end else begin : g_reg
            logic [W-1:0] r_dout;
            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    r_dout <= '0;
                end else if (clr) begin
                    r_dout <= '0;
                end else if (w_rd_ok) begin
                    r_dout <= w_rdata;
                end
            end
            assign dout = r_dout;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wl_sfifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_wl_sfifo
// Brief   : Directed self-checking bench for wl_sfifo (registered and FWFT).
// Revision: 1.0
// ============================================================================
module tb_wl_sfifo;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] din = 8'h00;
    logic       we = 1'b0;
    logic       re = 1'b0;

    logic [7:0] dout0, dout1;
    logic       wfull0, rempty0, awfull0, arempty0, overflow0, underflow0;
    logic       wfull1, rempty1, awfull1, arempty1, overflow1, underflow1;
    logic [2:0] count0, count1;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    wl_sfifo #(.W(8), .H(5), .TA(1), .TB(1), .FWFT(0)) dut0 (
        .clk(clk), .rst_b(rst_b), .clr(clr), .din(din), .we(we), .re(re),
        .dout(dout0), .wfull(wfull0), .rempty(rempty0), .awfull(awfull0),
        .arempty(arempty0), .overflow(overflow0), .underflow(underflow0),
        .count(count0)
    );

    wl_sfifo #(.W(8), .H(5), .TA(1), .TB(1), .FWFT(1)) dut1 (
        .clk(clk), .rst_b(rst_b), .clr(clr), .din(din), .we(we), .re(re),
        .dout(dout1), .wfull(wfull1), .rempty(rempty1), .awfull(awfull1),
        .arempty(arempty1), .overflow(overflow1), .underflow(underflow1),
        .count(count1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick;
        checks++; if (count0 !== 3'd0) $display("FAIL rst_count act=%0d exp=0", count0); else passes++;
        checks++; if (rempty0 !== 1'b1) $display("FAIL rst_rempty act=%b exp=1", rempty0); else passes++;
        checks++; if (arempty0 !== 1'b1) $display("FAIL rst_arempty act=%b exp=1", arempty0); else passes++;
        checks++; if (wfull0 !== 1'b0) $display("FAIL rst_wfull act=%b exp=0", wfull0); else passes++;
        checks++; if (awfull0 !== 1'b0) $display("FAIL rst_awfull act=%b exp=0", awfull0); else passes++;
        checks++; if (overflow0 !== 1'b0) $display("FAIL rst_overflow act=%b exp=0", overflow0); else passes++;
        checks++; if (underflow0 !== 1'b0) $display("FAIL rst_underflow act=%b exp=0", underflow0); else passes++;
        checks++; if (dout0 !== 8'h00) $display("FAIL rst_dout act=%h exp=00", dout0); else passes++;
        checks++; if (rempty1 !== 1'b1) $display("FAIL rst_rempty_fwft act=%b exp=1", rempty1); else passes++;
        rst_b = 1'b1;
        tick;
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 5; i++) begin
            din = 8'(i * 17);
            we  = 1'b1;
            tick;
            checks++; if (count0 !== 3'(i)) $display("FAIL fill_count i=%0d act=%0d exp=%0d", i, count0, i); else passes++;
            checks++; if (awfull0 !== (i >= 4)) $display("FAIL fill_awfull i=%0d act=%b exp=%b", i, awfull0, (i >= 4)); else passes++;
            checks++; if (wfull0 !== (i == 5)) $display("FAIL fill_wfull i=%0d act=%b exp=%b", i, wfull0, (i == 5)); else passes++;
            checks++; if (overflow0 !== 1'b0) $display("FAIL fill_overflow i=%0d act=%b exp=0", i, overflow0); else passes++;
        end
        din = 8'h66;
        tick;
        checks++; if (overflow0 !== 1'b1) $display("FAIL ovf_pulse act=%b exp=1", overflow0); else passes++;
        checks++; if (count0 !== 3'd5) $display("FAIL ovf_count act=%0d exp=5", count0); else passes++;
        we = 1'b0;
        tick;
        checks++; if (overflow0 !== 1'b0) $display("FAIL ovf_end act=%b exp=0", overflow0); else passes++;
    endtask

    task automatic test_drain;
        re = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick;
            checks++; if (dout0 !== 8'(i * 17)) $display("FAIL drain_dout i=%0d act=%h exp=%h", i, dout0, 8'(i * 17)); else passes++;
            checks++; if (count0 !== 3'(5 - i)) $display("FAIL drain_count i=%0d act=%0d exp=%0d", i, count0, 5 - i); else passes++;
            checks++; if (rempty0 !== (i == 5)) $display("FAIL drain_rempty i=%0d act=%b exp=%b", i, rempty0, (i == 5)); else passes++;
            checks++; if (arempty0 !== (i >= 4)) $display("FAIL drain_arempty i=%0d act=%b exp=%b", i, arempty0, (i >= 4)); else passes++;
        end
        tick;
        checks++; if (underflow0 !== 1'b1) $display("FAIL udf_pulse act=%b exp=1", underflow0); else passes++;
        checks++; if (dout0 !== 8'h55) $display("FAIL udf_dout act=%h exp=55", dout0); else passes++;
        re = 1'b0;
        tick;
        checks++; if (underflow0 !== 1'b0) $display("FAIL udf_end act=%b exp=0", underflow0); else passes++;
        checks++; if (dout0 !== 8'h55) $display("FAIL udf_hold act=%h exp=55", dout0); else passes++;
    endtask

    task automatic test_stream;
        we = 1'b1;
        din = 8'h01;
        tick;
        din = 8'h02;
        tick;
        checks++; if (count0 !== 3'd2) $display("FAIL prefill_count act=%0d exp=2", count0); else passes++;
        re = 1'b1;
        for (int i = 3; i <= 12; i++) begin
            din = 8'(i);
            tick;
            checks++; if (dout0 !== 8'(i - 2)) $display("FAIL stream_dout i=%0d act=%h exp=%h", i, dout0, 8'(i - 2)); else passes++;
            checks++; if (count0 !== 3'd2) $display("FAIL stream_count i=%0d act=%0d exp=2", i, count0); else passes++;
        end
        we = 1'b0;
        tick;
        checks++; if (dout0 !== 8'h0B) $display("FAIL stream_tail1 act=%h exp=0b", dout0); else passes++;
        tick;
        checks++; if (dout0 !== 8'h0C) $display("FAIL stream_tail2 act=%h exp=0c", dout0); else passes++;
        checks++; if (rempty0 !== 1'b1) $display("FAIL stream_empty act=%b exp=1", rempty0); else passes++;
        re = 1'b0;
    endtask

    task automatic test_simul;
        we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 8'hA1 + 8'(i);
            tick;
        end
        re = 1'b1;
        din = 8'hA4;
        tick;
        checks++; if (count0 !== 3'd3) $display("FAIL simul3_count act=%0d exp=3", count0); else passes++;
        checks++; if (dout0 !== 8'hA1) $display("FAIL simul3_dout act=%h exp=a1", dout0); else passes++;
        we = 1'b0;
        tick;
        tick;
        tick;
        checks++; if (dout0 !== 8'hA4) $display("FAIL simul3_last act=%h exp=a4", dout0); else passes++;
        checks++; if (count0 !== 3'd0) $display("FAIL simul3_drained act=%0d exp=0", count0); else passes++;
        we = 1'b1;
        din = 8'hB1;
        tick;
        checks++; if (count0 !== 3'd1) $display("FAIL simul0_count act=%0d exp=1", count0); else passes++;
        checks++; if (underflow0 !== 1'b1) $display("FAIL simul0_udf act=%b exp=1", underflow0); else passes++;
        checks++; if (dout0 !== 8'hA4) $display("FAIL simul0_dout act=%h exp=a4", dout0); else passes++;
        we = 1'b0;
        tick;
        checks++; if (dout0 !== 8'hB1) $display("FAIL simul0_read act=%h exp=b1", dout0); else passes++;
        checks++; if (underflow0 !== 1'b0) $display("FAIL simul0_udf_end act=%b exp=0", underflow0); else passes++;
        re = 1'b0;
    endtask

    task automatic test_clr;
        we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 8'hC1 + 8'(i);
            tick;
        end
        checks++; if (count0 !== 3'd3) $display("FAIL clr_pre act=%0d exp=3", count0); else passes++;
        clr = 1'b1;
        din = 8'h77;
        tick;
        clr = 1'b0;
        we = 1'b0;
        checks++; if (count0 !== 3'd0) $display("FAIL clr_count act=%0d exp=0", count0); else passes++;
        checks++; if (rempty0 !== 1'b1) $display("FAIL clr_rempty act=%b exp=1", rempty0); else passes++;
        checks++; if (dout0 !== 8'h00) $display("FAIL clr_dout act=%h exp=00", dout0); else passes++;
        checks++; if (overflow0 !== 1'b0) $display("FAIL clr_overflow act=%b exp=0", overflow0); else passes++;
        checks++; if (count1 !== 3'd0) $display("FAIL clr_count_fwft act=%0d exp=0", count1); else passes++;
        re = 1'b1;
        tick;
        checks++; if (underflow0 !== 1'b1) $display("FAIL clr_udf act=%b exp=1", underflow0); else passes++;
        checks++; if (dout0 !== 8'h00) $display("FAIL clr_noread act=%h exp=00", dout0); else passes++;
        re = 1'b0;
        we = 1'b1;
        din = 8'h88;
        tick;
        we = 1'b0;
        re = 1'b1;
        tick;
        re = 1'b0;
        checks++; if (dout0 !== 8'h88) $display("FAIL clr_after act=%h exp=88", dout0); else passes++;
    endtask

    task automatic test_fwft;
        we = 1'b1;
        din = 8'hA5;
        tick;
        checks++; if (rempty1 !== 1'b0) $display("FAIL fwft_rempty act=%b exp=0", rempty1); else passes++;
        checks++; if (dout1 !== 8'hA5) $display("FAIL fwft_first act=%h exp=a5", dout1); else passes++;
        din = 8'h5A;
        tick;
        checks++; if (dout1 !== 8'hA5) $display("FAIL fwft_hold act=%h exp=a5", dout1); else passes++;
        checks++; if (count1 !== 3'd2) $display("FAIL fwft_count act=%0d exp=2", count1); else passes++;
        we = 1'b0;
        re = 1'b1;
        tick;
        checks++; if (dout1 !== 8'h5A) $display("FAIL fwft_pop act=%h exp=5a", dout1); else passes++;
        re = 1'b0;
        we = 1'b1;
        din = 8'h3C;
        tick;
        we = 1'b0;
        checks++; if (count1 !== 3'd2) $display("FAIL fwft_refill act=%0d exp=2", count1); else passes++;
        // Drop reset between clock edges; outputs must respond with no edge.
        #2;
        rst_b = 1'b0;
        #1;
        checks++; if (count1 !== 3'd0) $display("FAIL arst_count act=%0d exp=0", count1); else passes++;
        checks++; if (rempty1 !== 1'b1) $display("FAIL arst_rempty act=%b exp=1", rempty1); else passes++;
        checks++; if (arempty1 !== 1'b1) $display("FAIL arst_arempty act=%b exp=1", arempty1); else passes++;
        checks++; if (wfull1 !== 1'b0) $display("FAIL arst_wfull act=%b exp=0", wfull1); else passes++;
        checks++; if (awfull1 !== 1'b0) $display("FAIL arst_awfull act=%b exp=0", awfull1); else passes++;
        checks++; if ((overflow1 | underflow1) !== 1'b0) $display("FAIL arst_pulses act=%b%b exp=00", overflow1, underflow1); else passes++;
        checks++; if (dout0 !== 8'h00) $display("FAIL arst_dout act=%h exp=00", dout0); else passes++;
        tick;
        rst_b = 1'b1;
        we = 1'b1;
        din = 8'h42;
        tick;
        we = 1'b0;
        checks++; if (dout1 !== 8'h42) $display("FAIL arst_restart act=%h exp=42", dout1); else passes++;
        checks++; if (count1 !== 3'd1) $display("FAIL arst_restart_cnt act=%0d exp=1", count1); else passes++;
    endtask

    initial begin
        test_reset;
        test_fill;
        test_drain;
        test_stream;
        test_simul;
        test_clr;
        test_fwft;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
